// File: rtl/punc_pkg.sv
// Shared PUnC encodings: opcodes, control FSM states and every datapath select code.
// The control unit and the datapath both import this package so the select codes match.
package punc_pkg;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_RTI  = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_RES  = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_EXEC2  = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [1:0] PC_SEL_OFF9      = 2'd0;
    localparam logic [1:0] PC_SEL_OFF11     = 2'd1;
    localparam logic [1:0] PC_SEL_BASE      = 2'd2;

    localparam logic [1:0] MEM_ADDR_PC      = 2'd0;
    localparam logic [1:0] MEM_ADDR_ALU     = 2'd1;
    localparam logic [1:0] MEM_ADDR_STORE   = 2'd2;

    localparam logic [1:0] RF_W_SEL_PC      = 2'd0;
    localparam logic [1:0] RF_W_SEL_MEM     = 2'd1;
    localparam logic [1:0] RF_W_SEL_ALU     = 2'd2;

    localparam logic [1:0] IMM_SEL_IMM5     = 2'd0;
    localparam logic [1:0] IMM_SEL_OFF6     = 2'd1;
    localparam logic [1:0] IMM_SEL_OFF9     = 2'd2;
    localparam logic [1:0] IMM_SEL_OFF11    = 2'd3;

    localparam logic [1:0] ALU_OP_ADD       = 2'd0;
    localparam logic [1:0] ALU_OP_AND       = 2'd1;
    localparam logic [1:0] ALU_OP_NOT       = 2'd2;
    localparam logic [1:0] ALU_OP_PASS      = 2'd3;

    localparam logic       ALU_A_PC         = 1'b0;
    localparam logic       ALU_A_RD0        = 1'b1;
    localparam logic       ALU_B_RD1        = 1'b0;
    localparam logic       ALU_B_IMM        = 1'b1;
    localparam logic       NZP_SEL_ALU      = 1'b0;
    localparam logic       NZP_SEL_MEM      = 1'b1;

    // Stores read their data register through port 1 using the DR field.
    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
    endfunction

endpackage

// File: rtl/punc_control_br_eval.sv
// Branch-taken evaluation: any requested condition that matches the current flags.
module punc_br_eval (
    input  logic [2:0] i_nzp_mask,
    input  logic       i_n,
    input  logic       i_z,
    input  logic       i_p,
    output logic       o_taken
);

    assign o_taken = (i_nzp_mask[2] & i_n) | (i_nzp_mask[1] & i_z) | (i_nzp_mask[0] & i_p);

endmodule

// File: rtl/punc_control.sv
// PUnC LC3 control FSM: INIT/FETCH/DECODE/EXEC/EXEC2/HALT driving every datapath control.
// Optional build macro PUNC_ILLEGAL_HALT_EN halts on opcodes 1000/1101 and flags illegal.
module punc_control
    import punc_pkg::*;
#(
    parameter int PC_INIT_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic        n,
    input  logic        z,
    input  logic        p,
    output logic        pc_ld,
    output logic [1:0]  pc_sel,
    output logic        pc_inc,
    output logic        ir_ld,
    output logic [1:0]  mem_addr_sel,
    output logic        mem_w_en,
    output logic        rf_w_en,
    output logic [1:0]  rf_w_sel,
    output logic [2:0]  rf_w_addr,
    output logic [2:0]  rf_r_addr_0,
    output logic [2:0]  rf_r_addr_1,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic [1:0]  imm_sel,
    output logic [1:0]  alu_op,
    output logic        nzp_ld,
    output logic        nzp_sel,
    output logic        store_ld,
    output logic        halted,
    output logic        illegal
);

    localparam logic [3:0] INIT_LAST = 4'(PC_INIT_WAIT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_init_cnt;
    logic [3:0]  w_op;
    logic        w_taken;
    logic        w_halt_op;
    logic        w_unused_ir;

    assign w_op        = ir[15:12];
    assign w_unused_ir = ^ir[4:3];

    punc_br_eval u_br_eval (
        .i_nzp_mask (ir[11:9]),
        .i_n        (n),
        .i_z        (z),
        .i_p        (p),
        .o_taken    (w_taken)
    );

`ifdef PUNC_ILLEGAL_HALT_EN
    logic r_illegal;

    assign w_halt_op = (w_op == OP_TRAP) || (w_op == OP_RTI) || (w_op == OP_RES);
    assign illegal   = r_illegal;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_illegal <= 1'b0;
        else if (r_state == S_DECODE && (w_op == OP_RTI || w_op == OP_RES))
            r_illegal <= 1'b1;
    end
`else
    assign w_halt_op = (w_op == OP_TRAP);
    assign illegal   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_INIT;
            r_init_cnt <= 4'd0;
        end else begin
            r_state    <= w_next;
            r_init_cnt <= (r_state == S_INIT) ? r_init_cnt + 4'd1 : 4'd0;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT:   if (r_init_cnt == INIT_LAST) w_next = S_FETCH;
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: w_next = w_halt_op ? S_HALT : S_EXEC;
            S_EXEC:   w_next = (w_op == OP_LDI || w_op == OP_STI) ? S_EXEC2 : S_FETCH;
            S_EXEC2:  w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_INIT;
        endcase
    end

    always_comb begin
        pc_ld        = 1'b0;
        pc_sel       = PC_SEL_OFF9;
        pc_inc       = 1'b0;
        ir_ld        = 1'b0;
        mem_addr_sel = MEM_ADDR_PC;
        mem_w_en     = 1'b0;
        rf_w_en      = 1'b0;
        rf_w_sel     = RF_W_SEL_PC;
        rf_w_addr    = 3'd0;
        rf_r_addr_0  = 3'd0;
        rf_r_addr_1  = 3'd0;
        alu_a_sel    = ALU_A_PC;
        alu_b_sel    = ALU_B_RD1;
        imm_sel      = IMM_SEL_IMM5;
        alu_op       = ALU_OP_ADD;
        nzp_ld       = 1'b0;
        nzp_sel      = NZP_SEL_ALU;
        store_ld     = 1'b0;
        halted       = 1'b0;

        if (r_state == S_DECODE || r_state == S_EXEC || r_state == S_EXEC2) begin
            rf_r_addr_0 = ir[8:6];
            rf_r_addr_1 = is_store(w_op) ? ir[11:9] : ir[2:0];
        end

        case (r_state)
            S_FETCH: begin
                mem_addr_sel = MEM_ADDR_PC;
                ir_ld        = 1'b1;
                pc_inc       = 1'b1;
            end
            S_EXEC: begin
                case (w_op)
                    OP_ADD, OP_AND, OP_NOT: begin
                        alu_a_sel = ALU_A_RD0;
                        alu_b_sel = ir[5];
                        imm_sel   = IMM_SEL_IMM5;
                        alu_op    = (w_op == OP_ADD) ? ALU_OP_ADD :
                                    (w_op == OP_AND) ? ALU_OP_AND : ALU_OP_NOT;
                        rf_w_en   = 1'b1;
                        rf_w_sel  = RF_W_SEL_ALU;
                        rf_w_addr = ir[11:9];
                        nzp_ld    = 1'b1;
                        nzp_sel   = NZP_SEL_ALU;
                    end
                    OP_BR: begin
                        pc_ld  = w_taken;
                        pc_sel = PC_SEL_OFF9;
                    end
                    OP_JMP: begin
                        pc_ld  = 1'b1;
                        pc_sel = PC_SEL_BASE;
                    end
                    OP_JSR: begin
                        rf_w_en   = 1'b1;
                        rf_w_addr = 3'd7;
                        rf_w_sel  = RF_W_SEL_PC;
                        pc_ld     = 1'b1;
                        pc_sel    = ir[11] ? PC_SEL_OFF11 : PC_SEL_BASE;
                    end
                    OP_LD, OP_LDR: begin
                        alu_a_sel    = (w_op == OP_LDR) ? ALU_A_RD0 : ALU_A_PC;
                        alu_b_sel    = ALU_B_IMM;
                        imm_sel      = (w_op == OP_LDR) ? IMM_SEL_OFF6 : IMM_SEL_OFF9;
                        alu_op       = ALU_OP_ADD;
                        mem_addr_sel = MEM_ADDR_ALU;
                        rf_w_en      = 1'b1;
                        rf_w_sel     = RF_W_SEL_MEM;
                        rf_w_addr    = ir[11:9];
                        nzp_ld       = 1'b1;
                        nzp_sel      = NZP_SEL_MEM;
                    end
                    OP_LEA: begin
                        alu_a_sel = ALU_A_PC;
                        alu_b_sel = ALU_B_IMM;
                        imm_sel   = IMM_SEL_OFF9;
                        alu_op    = ALU_OP_ADD;
                        rf_w_en   = 1'b1;
                        rf_w_sel  = RF_W_SEL_ALU;
                        rf_w_addr = ir[11:9];
                    end
                    OP_ST, OP_STR: begin
                        alu_a_sel    = (w_op == OP_STR) ? ALU_A_RD0 : ALU_A_PC;
                        alu_b_sel    = ALU_B_IMM;
                        imm_sel      = (w_op == OP_STR) ? IMM_SEL_OFF6 : IMM_SEL_OFF9;
                        alu_op       = ALU_OP_ADD;
                        mem_addr_sel = MEM_ADDR_ALU;
                        mem_w_en     = 1'b1;
                    end
                    // Indirect forms fetch the pointer into the store register first.
                    OP_LDI, OP_STI: begin
                        alu_a_sel    = ALU_A_PC;
                        alu_b_sel    = ALU_B_IMM;
                        imm_sel      = IMM_SEL_OFF9;
                        alu_op       = ALU_OP_ADD;
                        mem_addr_sel = MEM_ADDR_ALU;
                        store_ld     = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_EXEC2: begin
                mem_addr_sel = MEM_ADDR_STORE;
                if (w_op == OP_LDI) begin
                    rf_w_en   = 1'b1;
                    rf_w_sel  = RF_W_SEL_MEM;
                    rf_w_addr = ir[11:9];
                    nzp_ld    = 1'b1;
                    nzp_sel   = NZP_SEL_MEM;
                end else begin
                    mem_w_en = 1'b1;
                end
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/punc_control.md
Name: punc_control

Overview:
- Control unit for the PUnC LC3 processor; sits directly upstream of the PUnC datapath and drives every select, load and write-enable it consumes.
- Multi-cycle Moore/Mealy FSM: INIT, FETCH, DECODE, EXEC, EXEC2 (LDI/STI only), HALT.
- Inputs are the datapath's instruction register and N/Z/P condition codes.
- Outputs are combinational from state plus `ir` fields.

Parameters:
- `PC_INIT_WAIT`, 1: number of INIT cycles after reset release before the first FETCH (range 1–15).

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `ir` in 16: current instruction register contents.
- `n`, `z`, `p` in 1 each: condition-code flags.
- `pc_ld` out 1: load PC from the `pc_sel` source.
- `pc_sel` out 2: 0 = PC+sext(off9), 1 = PC+sext(off11), 2 = base register (`rd0`).
- `pc_inc` out 1: PC <= PC+1.
- `ir_ld` out 1: IR <= memory read data.
- `mem_addr_sel` out 2: 0 = PC, 1 = ALU result, 2 = store register.
- `mem_w_en` out 1: memory write; data is `rd1`.
- `rf_w_en` out 1: register-file write enable.
- `rf_w_sel` out 2: 0 = PC, 1 = memory data, 2 = ALU result.
- `rf_w_addr`, `rf_r_addr_0`, `rf_r_addr_1` out 3 each: register-file addresses.
- `alu_a_sel` out 1: 0 = PC, 1 = `rd0`.
- `alu_b_sel` out 1: 0 = `rd1`, 1 = sign-extended immediate.
- `imm_sel` out 2: 0 = imm5, 1 = off6, 2 = off9, 3 = off11.
- `alu_op` out 2: 0 = ADD, 1 = AND, 2 = NOT A, 3 = PASS A.
- `nzp_ld` out 1: load condition codes.
- `nzp_sel` out 1: 0 = ALU result, 1 = memory data.
- `store_ld` out 1: store register <= memory data.
- `halted` out 1: asserted in HALT.
- `illegal` out 1: illegal-opcode flag (see Optional Feature).

Behaviour:
- Reset: `rst` low forces state INIT asynchronously.
- Default outputs: in INIT every output is 0, and all outputs are 0 in any state unless stated below.
- INIT: held for `PC_INIT_WAIT` cycles via a 4-bit counter, then goes to FETCH.
- FETCH: `mem_addr_sel`=0, `ir_ld`=1, `pc_inc`=1; next state DECODE. PC seen in EXEC is already incremented.
- DECODE: no writes. Drives `rf_r_addr_0`=`ir[8:6]` and `rf_r_addr_1`=`ir[2:0]`, except ST/STI/STR where `rf_r_addr_1`=`ir[11:9]`. Next state: HALT if opcode 1111, else EXEC.
- Read addresses stay driven identically in EXEC and EXEC2.
- EXEC, keyed by `ir[15:12]`; next state FETCH unless noted.
  - ADD 0001 / AND 0101: `alu_a_sel`=1, `alu_b_sel`=`ir[5]`, `imm_sel`=0, `alu_op`=ADD or AND; `rf_w_en`=1, `rf_w_sel`=2, `rf_w_addr`=`ir[11:9]`; `nzp_ld`=1, `nzp_sel`=0.
  - NOT 1001: as ADD but `alu_op`=NOT.
  - BR 0000: taken = (`ir[11]`&`n`)|(`ir[10]`&`z`)|(`ir[9]`&`p`). If taken, `pc_ld`=1, `pc_sel`=0. nzp=000 is never taken.
  - JMP 1100: `pc_ld`=1, `pc_sel`=2.
  - JSR/JSRR 0100: `rf_w_en`=1, `rf_w_addr`=7, `rf_w_sel`=0, `pc_ld`=1, `pc_sel`=`ir[11]` ? 1 : 2. R7 and PC update on the same edge, so JSRR R7 jumps to the old R7 value.
  - LD 0010: `alu_a_sel`=0, `alu_b_sel`=1, `imm_sel`=2, `alu_op`=ADD, `mem_addr_sel`=1; `rf_w_en`=1, `rf_w_sel`=1, `rf_w_addr`=`ir[11:9]`; `nzp_ld`=1, `nzp_sel`=1.
  - LDR 0110: as LD but `alu_a_sel`=1, `imm_sel`=1.
  - LEA 1110: ALU = PC+off9, `rf_w_sel`=2, `rf_w_en`=1, `rf_w_addr`=`ir[11:9]`; no `nzp_ld`.
  - ST 0011: LD addressing, `mem_w_en`=1.
  - STR 0111: LDR addressing, `mem_w_en`=1.
  - LDI 1010 / STI 1011: LD addressing, `store_ld`=1; next state EXEC2.
  - RTI 1000 / reserved 1101: no-op.
- EXEC2: `mem_addr_sel`=2.
  - LDI: `rf_w_en`=1, `rf_w_sel`=1, `nzp_ld`=1, `nzp_sel`=1.
  - STI: `mem_w_en`=1.
  - Next state FETCH.
- HALT: `halted`=1; remains in HALT until reset.
- Latency: 3 cycles per instruction, 4 for LDI/STI.
- Reset mid-instruction aborts without completing the pending write; the first post-reset write is gated by INIT.

Optional Feature:
- Macro `PUNC_ILLEGAL_HALT_EN`.
- Defined: opcodes 1000/1101 go DECODE->HALT with `halted`=1 and `illegal`=1 (sticky until reset).
- Undefined: they execute as no-ops and `illegal` is tied 0.

Decomposition:
- Package `punc_pkg`: opcode localparams, state encoding, and all select-code constants (`pc_sel`, `mem_addr_sel`, `rf_w_sel`, `imm_sel`, `alu_op`). The datapath shares these constants.
- One natural sub-module, `punc_br_eval`: combinational branch-taken evaluation.

Test Plan:
- Reset, release after 2 cycles -> INIT holds all outputs 0 for 1 cycle, then FETCH with `ir_ld`=`pc_inc`=1.
- `ir`=0x1261 (ADD R1,R1,#1) -> EXEC: `alu_b_sel`=1, `imm_sel`=0, `rf_w_addr`=1, `rf_w_en`=1, `nzp_ld`=1; FETCH 3 cycles after the previous FETCH.
- `ir`=0x0A05 (BRnp) with `z`=1 -> `pc_ld`=0; same `ir` with `p`=1 -> `pc_ld`=1, `pc_sel`=0.
- `ir`=0xA402 (LDI) -> EXEC `store_ld`=1, `mem_addr_sel`=1; EXEC2 `mem_addr_sel`=2, `rf_w_sel`=1, `nzp_sel`=1; 4-cycle instruction.
- `ir`=0x41C0 (JSRR R7) -> `rf_w_addr`=7, `rf_w_sel`=0, `pc_sel`=2, `rf_r_addr_0`=7 in the same cycle.
- `ir`=0xF025 -> HALT, `halted`=1 persists for 20 cycles. `ir`=0xD000 -> HALT with `illegal`=1 when `PUNC_ILLEGAL_HALT_EN` is defined, otherwise returns to FETCH.
